rf_mem_2p: RTL and testbench

Parametrised pseudo dual-port register-file memory with one write port and one read port. It adds per-lane byte enables, write-first bypass for same-address accesses, a selectable 1- or 2-cycle read latency with a `rd_valid` qualifier, and a hardware clear sequencer that zeroes the array after reset or on request. It is the general storage primitive for the FIFOs and lookup tables that sit behind it.

---
 rtl/rf_mem_pkg.sv | 22 ++
 rtl/rf_mem_clr_seq.sv | 61 ++++++
 rtl/rf_mem_2p.sv | 169 ++++++++++++++++
 tb/tb_rf_mem_2p.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_mem_pkg.sv
// Shared types and helpers for the rf_mem_2p register-file memory.
// Holds the clear FSM states, the read-latency check and lane parity.
package rf_mem_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int PAR_W = 64;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic logic lane_parity(
    input logic [PAR_W-1:0] data
  );
    return ^data;
  endfunction

endpackage

// File: rtl/rf_mem_clr_seq.sv
// Clear sequencer: sweeps zeros into every word after reset or clr_req.
// The FSM is in READY (init_done) only once the last word has been zeroed.
module rf_mem_clr_seq
  import rf_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  rf_state_e             r_state;
  rf_state_e             w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      RF_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nx = RF_READY;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RF_READY: begin
        if (clr_req) w_state_nx = RF_CLEAR;
      end
      default: begin
        w_state_nx = RF_CLEAR;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign clr_we    = (r_state == RF_CLEAR);
  assign clr_addr  = r_cnt;
  assign init_done = (r_state == RF_READY);

endmodule

// File: rtl/rf_mem_2p.sv
// Pseudo dual-port register file: lane enables, write-first bypass,
// RD_LAT 1/2 read pipe, clear sweep. Parity via RF_MEM_2P_PARITY_EN.
module rf_mem_2p
  import rf_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_req,
  output logic                             init_done,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_perr
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("rf_mem_2p: RD_LAT must be 1 or 2");
  end

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_ready;

  rf_mem_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_done (w_ready)
  );

  assign init_done = w_ready;

  logic w_wr_inr;
  logic w_rd_inr;
  logic w_wr_ok;
  logic w_rd_acc;
  logic w_byp;

  assign w_wr_inr = ({1'b0, wr_addr} < DEPTH_W);
  assign w_rd_inr = ({1'b0, rd_addr} < DEPTH_W);
  assign w_wr_ok  = w_ready & wr_en & ~clr_req & w_wr_inr;
  assign w_rd_acc = w_ready & rd_en & ~clr_req;
  assign w_byp    = w_wr_ok & (wr_addr == rd_addr);

  // Clear sweep owns the write port while not READY
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [LANES-1:0]      w_wbe;

  assign w_we    = w_clr_we | w_wr_ok;
  assign w_waddr = w_clr_we ? w_clr_addr : wr_addr;
  assign w_wdata = w_clr_we ? '0 : wr_data;
  assign w_wbe   = w_clr_we ? '1 : wr_be;

  logic [DATA_WIDTH-1:0] r_ram [DEPTH];

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wbe[i])
          r_ram[w_waddr][i*LANE_WIDTH +: LANE_WIDTH] <=
            w_wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef RF_MEM_2P_PARITY_EN
  logic [LANES-1:0] r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wbe[i])
          r_par[w_waddr][i] <= lane_parity(
            PAR_W'(w_wdata[i*LANE_WIDTH +: LANE_WIDTH]));
      end
    end
  end
`endif

  logic [DATA_WIDTH-1:0] w_rword;
  logic                  w_rerr;

  // Bypassed lanes carry fresh parity, so only stored lanes can mismatch
  always_comb begin
    w_rword = '0;
    w_rerr  = 1'b0;
    if (w_rd_inr) begin
      w_rword = r_ram[rd_addr];
      for (int i = 0; i < LANES; i++) begin
        if (w_byp && wr_be[i]) begin
          w_rword[i*LANE_WIDTH +: LANE_WIDTH] =
            wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
`ifdef RF_MEM_2P_PARITY_EN
        else if (lane_parity(PAR_W'(
                   r_ram[rd_addr][i*LANE_WIDTH +: LANE_WIDTH]))
                 != r_par[rd_addr][i]) begin
          w_rerr = 1'b1;
        end
`endif
      end
    end
  end

  logic                  r_v1;
  logic                  r_e1;
  logic [DATA_WIDTH-1:0] r_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      r_e1 <= w_rd_acc & w_rerr;
      if (w_rd_acc) r_d1 <= w_rword;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  r_v2;
    logic                  r_e2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v2 <= 1'b0;
        r_e2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        r_e2 <= r_v1 & r_e1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rd_valid = r_v2;
    assign rd_perr  = r_e2;
    assign rd_data  = r_d2;
  end else begin : g_lat1
    assign rd_valid = r_v1;
    assign rd_perr  = r_e1;
    assign rd_data  = r_d1;
  end

endmodule

// File: tb/tb_rf_mem_2p.sv
// Bench for rf_mem_2p: two instances (16x16 lat1, 12x16 lat2) share
// stimulus and are compared every cycle against a word-level model.
module tb_rf_mem_2p;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be   = '0;

  logic        done0, done1, v0, v1, pe0, pe1;
  logic [15:0] d0, d1;

  int n_vec  = 0;
  int n_mis  = 0;
  int m_edge = 0;

  always #5 clk = ~clk;

  rf_mem_2p #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16),
    .LANE_WIDTH(8), .RD_LAT(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .init_done(done0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0),
    .rd_perr(pe0)
  );

  rf_mem_2p #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12),
    .LANE_WIDTH(8), .RD_LAT(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .init_done(done1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
    .rd_perr(pe1)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        p;
  } rd_t;

  logic [15:0] m_mem  [2][16];
  logic [1:0]  m_bad  [2][16];
  bit          m_done [2];
  int          m_left [2];
  logic [15:0] m_last [2];
  rd_t         q0[$];
  rd_t         q1[$];

  function automatic int dep(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      m_left[k] = dep(k);
      m_last[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(int k);
    rd_t         r;
    logic [15:0] mask;
    mask = {{8{wr_be[1]}}, {8{wr_be[0]}}};
    if (!m_done[k]) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        m_done[k] = 1'b1;
        for (int a = 0; a < 16; a++) begin
          m_mem[k][a] = '0;
          m_bad[k][a] = '0;
        end
      end
    end else if (clr_req) begin
      m_done[k] = 1'b0;
      m_left[k] = dep(k);
    end else begin
      if (rd_en) begin
        r.due = m_edge + lat(k) - 1;
        r.d   = '0;
        r.p   = 1'b0;
        if (int'(rd_addr) < dep(k)) begin
          r.d = m_mem[k][rd_addr];
          r.p = |m_bad[k][rd_addr];
          if (wr_en && wr_addr == rd_addr) begin
            r.d = (wr_data & mask) | (r.d & ~mask);
            r.p = |(m_bad[k][rd_addr] & ~wr_be);
          end
        end
        if (k == 0) q0.push_back(r);
        else q1.push_back(r);
      end
      if (wr_en && int'(wr_addr) < dep(k)) begin
        m_mem[k][wr_addr] =
          (wr_data & mask) | (m_mem[k][wr_addr] & ~mask);
        m_bad[k][wr_addr] = m_bad[k][wr_addr] & ~wr_be;
      end
    end
  endtask

  task automatic check_out(int k);
    rd_t  r;
    bit   ev;
    logic ep;
    ev = 1'b0;
    ep = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == m_edge) begin
        r  = q0.pop_front();
        ev = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == m_edge) begin
        r  = q1.pop_front();
        ev = 1'b1;
      end
    end
    if (ev) begin
      m_last[k] = r.d;
      ep        = r.p;
    end
    chk($sformatf("u%0d.init_done@%0d", k, m_edge),
        32'(k ? done1 : done0), 32'(m_done[k]));
    chk($sformatf("u%0d.rd_valid@%0d", k, m_edge),
        32'(k ? v1 : v0), 32'(ev));
    chk($sformatf("u%0d.rd_data@%0d", k, m_edge),
        32'(k ? d1 : d0), 32'(m_last[k]));
    chk($sformatf("u%0d.rd_perr@%0d", k, m_edge),
        32'(k ? pe1 : pe0), 32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    m_edge++;
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_out(0);
    check_out(1);
  endtask

  task automatic cyc(input bit we, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [1:0] be,
                     input bit re, input logic [3:0] ra,
                     input bit cr);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    clr_req = cr;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check_out(0);
    check_out(1);
    idle(3);
    rst_n = 1'b1;
    idle(16);

    for (int a = 0; a < 16; a++)
      cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a), 1'b0);
    idle(3);

    cyc(1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
    chk("merge_lat1", 32'(d0), 32'h0000AB34);
    chk("merge_lat1_v", 32'(v0), 32'd1);
    idle(1);
    chk("merge_lat2", 32'(d1), 32'h0000AB34);
    chk("merge_lat2_v", 32'(v1), 32'd1);

    cyc(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd5, 16'h00FF, 2'b10, 1'b1, 4'd5, 1'b0);
    chk("bypass_lat1", 32'(d0), 32'h00000011);
    idle(1);
    chk("bypass_lat2", 32'(d1), 32'h00000011);
    idle(2);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 4'($urandom), 16'($urandom),
          2'($urandom), 1'($urandom), 4'($urandom),
          ($urandom_range(0, 63) == 0));
    idle(20);

    cyc(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b0, 4'd0, 1'b1);
    chk("clr_done_low", 32'(done0), 32'd0);
    idle(16);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 1'b0);
    chk("clr_zeroed", 32'(d0), 32'd0);
    idle(2);

    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1, 1'b1);
    idle(5);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out(0);
    check_out(1);
    idle(1);
    rst_n = 1'b1;
    idle(15);
    chk("rst_sweep_busy", 32'(done0), 32'd0);
    idle(1);
    chk("rst_sweep_done", 32'(done0), 32'd1);

`ifdef RF_MEM_2P_PARITY_EN
    cyc(1'b1, 4'd2, 16'h5A5A, 2'b11, 1'b0, 4'd0, 1'b0);
    idle(1);
    u1.r_ram[2][0] = ~u1.r_ram[2][0];
    u2.r_ram[2][0] = ~u2.r_ram[2][0];
    for (int k = 0; k < 2; k++) begin
      m_mem[k][2][0] = ~m_mem[k][2][0];
      m_bad[k][2][0] = 1'b1;
    end
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2, 1'b0);
    chk("perr_flag", 32'(pe0), 32'd1);
    idle(2);
`endif

    for (int i = 0; i < 100; i++)
      cyc(1'($urandom), 4'($urandom), 16'($urandom),
          2'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
